// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and defaults for the modular-inverse controller and its GCD core.
package rsa_pkg;
    localparam int DEFAULT_WORD_WIDTH = 32;
    typedef enum logic [1:0] {OK, NO_INV, BAD_ARG, TIMEOUT} status_t;
    typedef enum logic [2:0] {IDLE, CHECK, CLEAR, RUN, NORM, DONE} state_t;
    typedef enum logic [1:0] {G_LOAD, G_SHIFT, G_LOOP, G_DONE} gcd_state_t;
endpackage

// File: rtl/extended_binary_gcd.sv
// extended_binary_gcd: one-step-per-cycle binary extended GCD, x*coeff_i + y*coeff_j = gcd.
module extended_binary_gcd
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] x,
    input  logic [WORD_WIDTH-1:0] y,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] gcd_result,
    output logic [WORD_WIDTH:0]   coeff_i
);
    localparam int CW = WORD_WIDTH + 2;
    localparam int KW = $clog2(WORD_WIDTH + 1);
    localparam int OW = WORD_WIDTH + 1;

    gcd_state_t st_q, st_d;
    logic [WORD_WIDTH-1:0] u_q, u_d, v_q, v_d, xs_q, xs_d, ys_q, ys_d;
    logic signed [CW-1:0] ca_q, ca_d, cb_q, cb_d, cc_q, cc_d, cd_q, cd_d;
    logic signed [CW-1:0] xe, ye;
    logic [KW-1:0] k_q, k_d;

    assign xe = $signed({2'b00, xs_q});
    assign ye = $signed({2'b00, ys_q});

    // u = ca*xs + cb*ys and v = cc*xs + cd*ys hold throughout G_LOOP
    always_comb begin
        st_d = st_q;
        u_d = u_q;
        v_d = v_q;
        xs_d = xs_q;
        ys_d = ys_q;
        ca_d = ca_q;
        cb_d = cb_q;
        cc_d = cc_q;
        cd_d = cd_q;
        k_d = k_q;
        if (en) begin
            case (st_q)
                G_LOAD: begin
                    u_d = x;
                    v_d = y;
                    ca_d = CW'(1);
                    cb_d = '0;
                    cc_d = '0;
                    cd_d = CW'(1);
                    k_d = '0;
                    st_d = G_SHIFT;
                end
                G_SHIFT: begin
                    if (!u_q[0] && !v_q[0]) begin
                        u_d = u_q >> 1;
                        v_d = v_q >> 1;
                        k_d = k_q + 1'b1;
                    end else begin
                        xs_d = u_q;
                        ys_d = v_q;
                        st_d = G_LOOP;
                    end
                end
                G_LOOP: begin
                    if (u_q == '0) begin
                        st_d = G_DONE;
                    end else if (!u_q[0]) begin
                        u_d = u_q >> 1;
                        ca_d = (ca_q[0] | cb_q[0]) ? (ca_q + ye) >>> 1 : ca_q >>> 1;
                        cb_d = (ca_q[0] | cb_q[0]) ? (cb_q - xe) >>> 1 : cb_q >>> 1;
                    end else if (!v_q[0]) begin
                        v_d = v_q >> 1;
                        cc_d = (cc_q[0] | cd_q[0]) ? (cc_q + ye) >>> 1 : cc_q >>> 1;
                        cd_d = (cc_q[0] | cd_q[0]) ? (cd_q - xe) >>> 1 : cd_q >>> 1;
                    end else if (u_q >= v_q) begin
                        u_d = u_q - v_q;
                        ca_d = ca_q - cc_q;
                        cb_d = cb_q - cd_q;
                    end else begin
                        v_d = v_q - u_q;
                        cc_d = cc_q - ca_q;
                        cd_d = cd_q - cb_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= G_LOAD;
            u_q <= '0;
            v_q <= '0;
            xs_q <= '0;
            ys_q <= '0;
            ca_q <= '0;
            cb_q <= '0;
            cc_q <= '0;
            cd_q <= '0;
            k_q <= '0;
        end else begin
            st_q <= st_d;
            u_q <= u_d;
            v_q <= v_d;
            xs_q <= xs_d;
            ys_q <= ys_d;
            ca_q <= ca_d;
            cb_q <= cb_d;
            cc_q <= cc_d;
            cd_q <= cd_d;
            k_q <= k_d;
        end
    end

    assign done = st_q == G_DONE;
    assign gcd_result = v_q << k_q;
    assign coeff_i = OW'(cc_q);
endmodule

// File: rtl/mod_inverse_ctrl.sv
// mod_inverse_ctrl: sequences the binary GCD core to return a^-1 mod m with status over valid/ready.
module mod_inverse_ctrl
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = 8 * WORD_WIDTH + 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_WIDTH-1:0] req_a,
    input  logic [WORD_WIDTH-1:0] req_m,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_inv,
    output logic [WORD_WIDTH-1:0] rsp_gcd,
    output logic [1:0]            rsp_status
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state_q, state_d;
    status_t status_q, status_d;
    logic [WORD_WIDTH-1:0] a_q, a_d, m_q, m_d, inv_q, inv_d, gcd_q, gcd_d;
    logic signed [WORD_WIDTH:0] c_q, c_d, m_ext;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic core_rst_n, core_en, core_done, timeout;
    logic [WORD_WIDTH-1:0] core_gcd;
    logic [WORD_WIDTH:0] core_coeff_i;

    assign m_ext = $signed({1'b0, m_q});
    assign core_rst_n = reset & (state_q != CLEAR);
    assign core_en = state_q == RUN;
    assign timeout = (state_q == RUN || state_q == NORM) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    extended_binary_gcd #(.WORD_WIDTH(WORD_WIDTH)) u_gcd (
        .clk       (clk),
        .rst_n     (core_rst_n),
        .en        (core_en),
        .x         (a_q),
        .y         (m_q),
        .done      (core_done),
        .gcd_result(core_gcd),
        .coeff_i   (core_coeff_i)
    );

    always_comb begin
        state_d = state_q;
        status_d = status_q;
        a_d = a_q;
        m_d = m_q;
        inv_d = inv_q;
        gcd_d = gcd_q;
        c_d = c_q;
        cnt_d = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d = req_a;
                    m_d = req_m;
                    req_ready_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (a_q == '0 || m_q < WORD_WIDTH'(2)) begin
                    state_d = DONE;
                    status_d = BAD_ARG;
                    inv_d = '0;
                    gcd_d = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (core_done) begin
                    c_d = $signed(core_coeff_i);
                    gcd_d = core_gcd;
                    if (core_gcd != WORD_WIDTH'(1)) begin
                        state_d = DONE;
                        status_d = NO_INV;
                        inv_d = '0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                cnt_d = cnt_q + 1'b1;
                if (c_q[WORD_WIDTH]) begin
                    c_d = c_q + m_ext;
                end else if (c_q >= m_ext) begin
                    c_d = c_q - m_ext;
                end else begin
                    state_d = DONE;
                    status_d = OK;
                    inv_d = c_q[WORD_WIDTH-1:0];
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = DONE;
            status_d = TIMEOUT;
            inv_d = '0;
            gcd_d = '0;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            status_q <= OK;
            a_q <= '0;
            m_q <= '0;
            inv_q <= '0;
            gcd_q <= '0;
            c_q <= '0;
            cnt_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            status_q <= status_d;
            a_q <= a_d;
            m_q <= m_d;
            inv_q <= inv_d;
            gcd_q <= gcd_d;
            c_q <= c_d;
            cnt_q <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_inv = inv_q;
    assign rsp_gcd = gcd_q;
    assign rsp_status = status_q;
endmodule

// File: tb/tb_mod_inverse_ctrl.sv
// tb_mod_inverse_ctrl: directed scoreboard bench for mod_inverse_ctrl against an Euclid reference.
module tb_mod_inverse_ctrl;
    localparam logic [1:0] S_OK = 2'd0, S_NO_INV = 2'd1, S_BAD_ARG = 2'd2;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] inv;
        logic [31:0] gcd;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_a = '0, req_m = '0;
    logic req_ready, rsp_valid;
    logic [31:0] rsp_inv, rsp_gcd;
    logic [1:0] rsp_status;
    int n_vec = 0, n_err = 0;
    exp_t exp_q[$];

    mod_inverse_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inv   (rsp_inv),
        .rsp_gcd   (rsp_gcd),
        .rsp_status(rsp_status)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input longint a, input longint m);
        exp_t e;
        longint r0, r1, s0, s1, q, t;
        if (a == 0 || m < 2) begin
            e.st = S_BAD_ARG;
            e.inv = '0;
            e.gcd = '0;
            return e;
        end
        r0 = a;
        r1 = m;
        s0 = 1;
        s1 = 0;
        while (r1 != 0) begin
            q = r0 / r1;
            t = r0 - q * r1;
            r0 = r1;
            r1 = t;
            t = s0 - q * s1;
            s0 = s1;
            s1 = t;
        end
        e.gcd = 32'(r0);
        if (r0 != 1) begin
            e.st = S_NO_INV;
            e.inv = '0;
        end else begin
            s0 = s0 % m;
            if (s0 < 0) s0 += m;
            e.st = S_OK;
            e.inv = 32'(s0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] m, input bit push);
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_a = a;
        req_m = m;
        if (push) exp_q.push_back(model(longint'(a), longint'(m)));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv(input bit hold);
        exp_t e;
        wait_rsp();
        if (!rsp_valid) begin
            chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("rsp_status", 32'(rsp_status), 32'(e.st));
        chk("rsp_inv", rsp_inv, e.inv);
        chk("rsp_gcd", rsp_gcd, e.gcd);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready), 32'd1);
        if (!hold) rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] dir_a[7] = '{32'd11, 32'd40, 32'd3, 32'd17, 32'd6, 32'd0, 32'd5};
        logic [31:0] dir_m[7] = '{32'd29, 32'd29, 32'd7, 32'd3120, 32'd9, 32'd29, 32'd1};
        logic [31:0] b2b_a[3] = '{32'd7, 32'd12, 32'hFFFF_FFF1};
        logic [31:0] b2b_m[3] = '{32'd40, 32'd18, 32'hFFFF_FFFE};
        exp_t e;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_inv", rsp_inv, 32'd0);
        chk("reset_rsp_gcd", rsp_gcd, 32'd0);
        chk("reset_rsp_status", 32'(rsp_status), 32'(S_OK));
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(dir_a[i], dir_m[i], 1'b1);
            recv(1'b0);
        end

        send(32'd11, 32'd29, 1'b1);
        wait_rsp();
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_a = 32'd3;
            req_m = 32'd7;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_inv", rsp_inv, e.inv);
            chk("bp_rsp_gcd", rsp_gcd, e.gcd);
            chk("bp_rsp_status", 32'(rsp_status), 32'(e.st));
            @(negedge clk);
        end
        req_valid = 1'b0;
        recv(1'b0);
        repeat (3) @(negedge clk);
        chk("bp_no_stray_rsp", 32'(rsp_valid), 32'd0);

        send(32'd11, 32'd29, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_status", 32'(rsp_status), 32'(S_OK));
        reset = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        send(32'd3, 32'd7, 1'b1);
        recv(1'b0);

        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(b2b_a[i], b2b_m[i], 1'b1);
            recv(1'b1);
        end
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
